// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM with byte-enable writes, selectable read-during-write behaviour,
// 1/2-cycle registered read with valid strobe, and a sequencer that fills the array after reset.
module ram_sdp_init #(
  parameter int              AW        = 8,
  parameter int              DW        = 32,
  parameter int              RD_LAT    = 1,
  parameter int              RDW_MODE  = 0,
  parameter int              INIT_MODE = 1,
  parameter logic [DW-1:0]   INIT_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              ready,
  input  logic              w_en,
  input  logic [AW-1:0]     w_addr,
  input  logic [DW/8-1:0]   w_be,
  input  logic [DW-1:0]     w_data,
  input  logic              r_en,
  input  logic [AW-1:0]     r_addr,
  output logic [DW-1:0]     r_data,
  output logic              r_valid
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam bit LAT2  = (RD_LAT == 2);

  typedef enum logic {ST_INIT, ST_READY} state_e;
  localparam state_e RST_STATE = (INIT_MODE != 0) ? ST_INIT : ST_READY;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            s1_valid_q, s1_valid_d;
  logic [DW-1:0]   s1_data_q, s1_data_d;
  logic            r_valid_q, r_valid_d;
  logic [DW-1:0]   r_data_q, r_data_d;

  logic [DW-1:0]   mem [DEPTH];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [NB-1:0]   wr_be;
  logic [DW-1:0]   wr_data;
  logic            rd_fire;
  logic [DW-1:0]   old_word, merged_word, rd_word;
  logic            src_valid;
  logic [DW-1:0]   src_data;

  // NOTE: every flop uses non-blocking assignment; mixing in blocking here creates sim/synth races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: each always_comb assigns defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == '1) state_d = ST_READY;
      end
      ST_READY: begin
        if (init_req && (INIT_MODE != 0)) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    ready   = (state_q == ST_READY);
    wr_en   = 1'b0;
    wr_addr = w_addr;
    wr_be   = w_be;
    wr_data = w_data;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_be   = '1;
      wr_data = (INIT_MODE == 2) ? INIT_VAL : DW'(cnt_q);
    end else begin
      wr_en   = w_en && (|w_be);
    end
  end

  // NOTE: the array is deliberately not reset; only the sequencer gives it defined contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // Write-first merge only applies when the write is actually accepted this cycle.
  always_comb begin
    rd_fire  = ready && r_en;
    old_word = mem[r_addr];
    for (int k = 0; k < NB; k++) begin
      merged_word[8*k +: 8] = w_be[k] ? w_data[8*k +: 8] : old_word[8*k +: 8];
    end
    rd_word = old_word;
    if ((RDW_MODE == 1) && ready && w_en && (w_addr == r_addr)) rd_word = merged_word;
  end

  always_comb begin
    s1_valid_d = LAT2 && rd_fire;
    s1_data_d  = rd_fire ? rd_word : s1_data_q;
    src_valid  = LAT2 ? s1_valid_q : rd_fire;
    src_data   = LAT2 ? s1_data_q  : rd_word;
    r_valid_d  = src_valid;
    r_data_d   = src_valid ? src_data : r_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
    end
  end

  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;

endmodule

// File: tb/tb_ram_sdp_init.sv
// Directed bench: five RAM variants share one stimulus stream and are checked against
// hand-computed values for fill, byte writes, read-during-write, latency and re-init.
module tb_ram_sdp_init;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_req = 1'b0;
  logic        w_en = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [3:0]  w_be = '0;
  logic [31:0] w_data = '0;
  logic        r_en = 1'b0;
  logic [3:0]  r_addr = '0;

  logic [31:0] rd [5];
  logic        rv [5];
  logic        rdy [5];

  // Samples one posedge after the request (c_) and one posedge later (d_).
  logic [31:0] c_rd [5];
  logic        c_rv [5];
  logic [31:0] d_rd [5];
  logic        d_rv [5];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // u0: index fill, old-data, latency 1
  ram_sdp_init #(.AW(4), .DW(32), .RD_LAT(1), .RDW_MODE(0), .INIT_MODE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(rdy[0]),
    .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(rd[0]), .r_valid(rv[0]));
  // u1: write-first
  ram_sdp_init #(.AW(4), .DW(32), .RD_LAT(1), .RDW_MODE(1), .INIT_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(rdy[1]),
    .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(rd[1]), .r_valid(rv[1]));
  // u2: latency 2
  ram_sdp_init #(.AW(4), .DW(32), .RD_LAT(2), .RDW_MODE(0), .INIT_MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(rdy[2]),
    .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(rd[2]), .r_valid(rv[2]));
  // u3: constant fill
  ram_sdp_init #(.AW(4), .DW(32), .RD_LAT(1), .RDW_MODE(0), .INIT_MODE(2),
                 .INIT_VAL(32'hDEADBEEF)) u3 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(rdy[3]),
    .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(rd[3]), .r_valid(rv[3]));
  // u4: no init
  ram_sdp_init #(.AW(4), .DW(32), .RD_LAT(1), .RDW_MODE(0), .INIT_MODE(0)) u4 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(rdy[4]),
    .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(rd[4]), .r_valid(rv[4]));

  task automatic drive_cycle(input logic we, input logic [3:0] wa, input logic [3:0] be,
                             input logic [31:0] wd, input logic re, input logic [3:0] ra);
    @(negedge clk);
    w_en = we; w_addr = wa; w_be = be; w_data = wd; r_en = re; r_addr = ra;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin c_rd[i] = rd[i]; c_rv[i] = rv[i]; end
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; w_be = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin d_rd[i] = rd[i]; d_rv[i] = rv[i]; end
  endtask

  // Counts further posedges until u0 reports ready; bounded so a stuck fill still ends.
  task automatic wait_ready(inout int n);
    while (!rdy[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b exp 0", rdy[0]); end
    checks++; if (rv[0] !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b exp 0", rv[0]); end
    checks++; if (rd[0] !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h exp 0", rd[0]); end
    checks++; if (rv[2] !== 1'b0 || rd[2] !== 32'h0) begin failures++; $display("FAIL reset_lat2: got %b/%h exp 0/0", rv[2], rd[2]); end
    checks++; if (rdy[4] !== 1'b1) begin failures++; $display("FAIL reset_noinit_ready: got %b exp 1", rdy[4]); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    wait_ready(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL fill_cycles: got %0d exp 16", n); end
    checks++; if (rdy[2] !== 1'b1 || rdy[3] !== 1'b1) begin failures++; $display("FAIL fill_ready_all: got %b%b exp 11", rdy[2], rdy[3]); end
  endtask

  task automatic test_index_fill;
    for (int a = 0; a < 16; a++) begin
      drive_cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(a));
      checks++; if (c_rd[0] !== 32'(a)) begin failures++; $display("FAIL idx_data[%0d]: got %h exp %h", a, c_rd[0], 32'(a)); end
      checks++; if (c_rv[0] !== 1'b1) begin failures++; $display("FAIL idx_valid[%0d]: got %b exp 1", a, c_rv[0]); end
      checks++; if (d_rv[0] !== 1'b0 || d_rd[0] !== 32'(a)) begin failures++; $display("FAIL idx_hold[%0d]: got %b/%h exp 0/%h", a, d_rv[0], d_rd[0], 32'(a)); end
      checks++; if (c_rv[2] !== 1'b0 || d_rv[2] !== 1'b1 || d_rd[2] !== 32'(a)) begin failures++; $display("FAIL idx_lat2[%0d]: got %b%b/%h exp 01/%h", a, c_rv[2], d_rv[2], d_rd[2], 32'(a)); end
    end
  endtask

  task automatic test_const_fill;
    drive_cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd3);
    checks++; if (c_rd[3] !== 32'hDEADBEEF) begin failures++; $display("FAIL const_a3: got %h exp deadbeef", c_rd[3]); end
    drive_cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd15);
    checks++; if (c_rd[3] !== 32'hDEADBEEF) begin failures++; $display("FAIL const_a15: got %h exp deadbeef", c_rd[3]); end
  endtask

  task automatic test_byte_write;
    drive_cycle(1'b1, 4'd5, 4'b0101, 32'h11223344, 1'b0, 4'd0);
    drive_cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd5);
    checks++; if (c_rd[0] !== 32'h00220044) begin failures++; $display("FAIL be_idx: got %h exp 00220044", c_rd[0]); end
    checks++; if (c_rd[3] !== 32'hDE22BE44) begin failures++; $display("FAIL be_const: got %h exp de22be44", c_rd[3]); end
    drive_cycle(1'b1, 4'd6, 4'b0000, 32'hFFFFFFFF, 1'b0, 4'd0);
    drive_cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd6);
    checks++; if (c_rd[0] !== 32'h6) begin failures++; $display("FAIL be_zero: got %h exp 00000006", c_rd[0]); end
  endtask

  task automatic test_rdw;
    drive_cycle(1'b1, 4'd7, 4'hF, 32'hAAAAAAAA, 1'b1, 4'd7);
    checks++; if (c_rd[0] !== 32'h7) begin failures++; $display("FAIL rdw_old: got %h exp 00000007", c_rd[0]); end
    checks++; if (c_rd[1] !== 32'hAAAAAAAA) begin failures++; $display("FAIL rdw_new: got %h exp aaaaaaaa", c_rd[1]); end
    checks++; if (d_rd[2] !== 32'h7) begin failures++; $display("FAIL rdw_old_lat2: got %h exp 00000007", d_rd[2]); end
    drive_cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd7);
    checks++; if (c_rd[0] !== 32'hAAAAAAAA) begin failures++; $display("FAIL rdw_after_old: got %h exp aaaaaaaa", c_rd[0]); end
    checks++; if (c_rd[1] !== 32'hAAAAAAAA) begin failures++; $display("FAIL rdw_after_new: got %h exp aaaaaaaa", c_rd[1]); end
    drive_cycle(1'b1, 4'd8, 4'hF, 32'h55555555, 1'b1, 4'd9);
    checks++; if (c_rd[1] !== 32'h9) begin failures++; $display("FAIL rdw_diff_addr: got %h exp 00000009", c_rd[1]); end
  endtask

  task automatic test_back_to_back;
    logic        exp_v2 [5];
    logic [31:0] exp_d2 [5];
    logic        exp_v0 [5];
    exp_v2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d2 = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h3};
    exp_v0 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      r_en = (c < 3);
      r_addr = 4'(c + 1);
      @(posedge clk); #1;
      checks++; if (rv[2] !== exp_v2[c]) begin failures++; $display("FAIL b2b_valid2[%0d]: got %b exp %b", c, rv[2], exp_v2[c]); end
      if (c > 0) begin
        checks++; if (rd[2] !== exp_d2[c]) begin failures++; $display("FAIL b2b_data2[%0d]: got %h exp %h", c, rd[2], exp_d2[c]); end
      end
      checks++; if (rv[0] !== exp_v0[c]) begin failures++; $display("FAIL b2b_valid1[%0d]: got %b exp %b", c, rv[0], exp_v0[c]); end
    end
    @(negedge clk);
    r_en = 1'b0;
  endtask

  task automatic test_init_req;
    int n;
    drive_cycle(1'b1, 4'd2, 4'hF, 32'h000000FF, 1'b0, 4'd0);
    @(negedge clk);
    init_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL initreq_drop: got %b exp 0", rdy[0]); end
    checks++; if (rdy[4] !== 1'b1) begin failures++; $display("FAIL initreq_noinit: got %b exp 1", rdy[4]); end
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      init_req = (c == 1);
      w_en = 1'b1; w_addr = 4'd2; w_be = 4'hF; w_data = 32'h12345678;
      r_en = 1'b1; r_addr = 4'd2;
      @(posedge clk); #1;
      n++;
      checks++; if (rv[0] !== 1'b0 || rv[2] !== 1'b0) begin failures++; $display("FAIL init_rvalid[%0d]: got %b%b exp 00", c, rv[0], rv[2]); end
    end
    @(negedge clk);
    init_req = 1'b0; w_en = 1'b0; r_en = 1'b0; w_be = '0;
    wait_ready(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL reinit_cycles: got %0d exp 16", n); end
    drive_cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd2);
    checks++; if (c_rd[0] !== 32'h2) begin failures++; $display("FAIL reinit_a2: got %h exp 00000002", c_rd[0]); end
    checks++; if (d_rd[2] !== 32'h2) begin failures++; $display("FAIL reinit_a2_lat2: got %h exp 00000002", d_rd[2]); end
    checks++; if (c_rd[3] !== 32'hDEADBEEF) begin failures++; $display("FAIL reinit_const: got %h exp deadbeef", c_rd[3]); end
  endtask

  task automatic test_reset_mid_fill;
    int n;
    @(negedge clk);
    init_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b exp 0", rdy[0]); end
    checks++; if (rd[0] !== 32'h0 || rd[2] !== 32'h0) begin failures++; $display("FAIL midrst_rdata: got %h/%h exp 0/0", rd[0], rd[2]); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    wait_ready(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL midrst_cycles: got %0d exp 16", n); end
    drive_cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd9);
    checks++; if (c_rd[0] !== 32'h9) begin failures++; $display("FAIL midrst_a9: got %h exp 00000009", c_rd[0]); end
    drive_cycle(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd12);
    checks++; if (c_rd[0] !== 32'hC) begin failures++; $display("FAIL midrst_a12: got %h exp 0000000c", c_rd[0]); end
  endtask

  initial begin
    test_reset;
    test_index_fill;
    test_const_fill;
    test_byte_write;
    test_rdw;
    test_back_to_back;
    test_init_req;
    test_reset_mid_fill;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_sdp_init.md
Name: ram_sdp_init

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, both on clk.
- Generalises the team's behavioural RAM with:
  - byte-enable writes;
  - selectable read-during-write semantics;
  - 1- or 2-cycle read latency with a valid strobe;
  - a synthesizable init sequencer that fills the array after reset or on request, replacing per-word async reset loading.
- Used as a scratch/weight store in the rsim datapath.

Parameters:
- AW, 8: address width; depth = 2**AW words.
- DW, 32: data width; must be a multiple of 8.
- RD_LAT, 1: read latency in cycles, 1 or 2. A value of 2 adds an output register stage.
- RDW_MODE, 0: same-address read/write in the same cycle. 0 = old data, 1 = new data (write-first, byte-merged).
- INIT_MODE, 1: fill pattern. 0 = no init, 1 = word index, 2 = constant INIT_VAL.
- INIT_VAL, 0: constant fill value for INIT_MODE=2, DW bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_req  in  1  one-cycle pulse; restarts the fill sequence when ready=1.
- ready  out  1  array initialised; user ports accepted.
- w_en  in  1  write strobe.
- w_addr  in  AW  write address.
- w_be  in  DW/8  byte enables; bit k covers w_data[8k+7:8k].
- w_data  in  DW  write data.
- r_en  in  1  read strobe.
- r_addr  in  AW  read address.
- r_data  out  DW  read data; holds its last value when no read completes.
- r_valid  out  1  r_data carries the result of the read issued RD_LAT cycles earlier.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - r_data=0, r_valid=0, pipeline stage cleared, fill counter=0.
  - State = INIT if INIT_MODE!=0, else READY.
  - ready=0 in INIT, 1 in READY.
  - Array contents are not reset.
- State machine has two states, INIT and READY.
  - INIT: at each posedge, mem[cnt] <= pattern, then cnt increments.
    - Pattern for INIT_MODE=1 is cnt zero-extended, or truncated, to DW. For INIT_MODE=2 it is INIT_VAL.
    - All bytes are written.
    - At the posedge that writes address 2**AW-1, state goes to READY and ready=1 from the next cycle.
    - The fill therefore takes exactly 2**AW cycles after the first posedge with rst_n=1.
  - READY: init_req=1 at a posedge moves to INIT with cnt=0, and ready drops the next cycle.
    - init_req is ignored in INIT, and always ignored when INIT_MODE=0.
- While in INIT:
  - w_en and r_en are ignored and user writes are dropped.
  - r_valid stays 0. Reads already in flight in the RD_LAT=2 stage still complete.
- Write (READY, w_en=1): bytes with w_be[k]=1 update, other bytes are kept. w_be=0 is a no-op.
- Read (READY, r_en=1):
  - RD_LAT=1: r_data/r_valid update at the same posedge.
  - RD_LAT=2: they update one posedge later.
  - r_valid is 1 for exactly one cycle per accepted read; back-to-back reads give r_valid high every cycle.
  - When no read completes, r_valid=0 and r_data holds.
- Same-cycle read and write to the same address:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: enabled bytes from w_data, others from the old word.
  - Different addresses do not interact.
- Reset asserted mid-fill or mid-read: the sequence aborts, the pipeline is cleared, and the fill restarts from address 0 after release.
- Addresses are always in range (depth = 2**AW). No out-of-range handling is needed.

Test Plan:
- AW=4, DW=32, INIT_MODE=1: release reset, then wait.
  - ready rises exactly 16 cycles after the first active posedge.
  - Reading addresses 0..15 returns 0..15, with r_valid high 1 cycle after each r_en (RD_LAT=1).
- INIT_MODE=2, INIT_VAL=32'hDEADBEEF: after the fill, read addresses 3 and 15 -> both return 32'hDEADBEEF.
- Write 32'h11223344 to address 5 with w_be=4'b0101 over the index fill (address 5 holds 5) -> read addresses 5 returns 32'h00220044.
- Same-cycle read and write to address 7: w_data=32'hAAAAAAAA, w_be=4'b1111, with address 7 holding 7.
  - RDW_MODE=0 returns 32'h00000007.
  - RDW_MODE=1 returns 32'hAAAAAAAA.
  - A following read returns 32'hAAAAAAAA in both modes.
- RD_LAT=2, reads of addresses 1,2,3 on consecutive cycles -> r_valid high for 3 cycles, starting 2 cycles after the first r_en, with data 1,2,3.
- Write 32'hFF to address 2, pulse init_req, issue w_en and r_en during INIT, then wait for ready.
  - During INIT, r_valid stays 0 and the writes have no effect.
  - After ready, address 2 reads 2.
  - Assert rst_n=0 at fill address 9 -> ready=0 and the fill restarts at 0, taking 16 cycles.
